ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 157 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the
// device, acknowledge check, watchdog. Lines are driven through active-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low,
  output logic       busy,
  output logic       done_tick,
  output logic       ack_err
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RTS_LAST  = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RTS, S_REQ, S_SEND, S_ACK, S_WAIT
  } state_t;

  state_t                state_reg, state_next;
  logic [FILTER_LEN-1:0] filt_reg, filt_next;
  logic                  fc_reg, fc_next, fall_edge;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [3:0]            n_reg, n_next;
  logic [9:0]            frame_reg, frame_next;
  logic                  c_low_next, d_low_next, busy_next, done_next, err_next;
  logic                  wdog_hit, wdog_active;

  // Filtered clock only moves on a unanimous window, so short glitches hold it.
  assign filt_next = {ps2c_in, filt_reg[FILTER_LEN-1:1]};
  assign fc_next   = (&filt_next) ? 1'b1 : ((|filt_next) ? fc_reg : 1'b0);
  assign fall_edge = fc_reg & ~fc_next;

  assign wdog_active = (state_reg == S_SEND) || (state_reg == S_ACK) || (state_reg == S_WAIT);
  assign wdog_hit    = wdog_active && (cnt_reg == WDOG_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      filt_reg       <= '1;
      fc_reg         <= 1'b1;
      cnt_reg        <= '0;
      n_reg          <= '0;
      frame_reg      <= '0;
      ps2c_drive_low <= 1'b0;
      ps2d_drive_low <= 1'b0;
      busy           <= 1'b0;
      done_tick      <= 1'b0;
      ack_err        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      filt_reg       <= filt_next;
      fc_reg         <= fc_next;
      cnt_reg        <= cnt_next;
      n_reg          <= n_next;
      frame_reg      <= frame_next;
      ps2c_drive_low <= c_low_next;
      ps2d_drive_low <= d_low_next;
      busy           <= busy_next;
      done_tick      <= done_next;
      ack_err        <= err_next;
    end
  end

  // Handshake: wr_ps2 is a one-cycle request taken only while busy is low; busy
  // acts as not-ready and stays high from the accepting edge until IDLE again.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    n_next     = n_reg;
    frame_next = frame_reg;
    c_low_next = ps2c_drive_low;
    d_low_next = ps2d_drive_low;
    busy_next  = busy;
    done_next  = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        c_low_next = 1'b0;
        d_low_next = 1'b0;
        if (wr_ps2) begin
          frame_next = {1'b1, ~^din, din};
          busy_next  = 1'b1;
          cnt_next   = '0;
          c_low_next = 1'b1;
          state_next = S_RTS;
        end
      end
      S_RTS: begin
        if (cnt_reg == RTS_LAST) begin
          d_low_next = 1'b1;
          state_next = S_REQ;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_REQ: begin
        // Release the clock; data stays low as the start bit.
        c_low_next = 1'b0;
        d_low_next = 1'b1;
        cnt_next   = '0;
        n_next     = '0;
        state_next = S_SEND;
      end
      S_SEND: begin
        cnt_next = cnt_reg + 1'b1;
        if (fall_edge) begin
          d_low_next = ~frame_reg[n_reg];
          n_next     = n_reg + 1'b1;
          if (n_reg == 4'd9) state_next = S_ACK;
        end
      end
      S_ACK: begin
        cnt_next = cnt_reg + 1'b1;
        if (fall_edge) begin
          done_next  = ~ps2d_in;
          err_next   = ps2d_in;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (fc_reg && ps2d_in) begin
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase

    // Watchdog overrides whatever the frame logic decided this cycle.
    if (wdog_hit) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      c_low_next = 1'b0;
      d_low_next = 1'b0;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      err_next   = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a device model that clocks frames;
// results are matched against an expected queue filled when each command is issued.
module tb_ps2_host_tx;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 2000;
  localparam int FLEN    = 8;
  localparam int HALF    = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_drive_low, ps2d_drive_low;
  logic       busy, done_tick, ack_err;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic [9:0] dev_cap;

  // entry = {ack_err, done_tick, stop, parity, data[7:0]}
  logic [11:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign ps2c_in = ~ps2c_drive_low & dev_c;
  assign ps2d_in = ~ps2d_drive_low & dev_d;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_LEN(FLEN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_ps2(wr_ps2),
    .din(din),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .ps2c_drive_low(ps2c_drive_low),
    .ps2d_drive_low(ps2d_drive_low),
    .busy(busy),
    .done_tick(done_tick),
    .ack_err(ack_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue a command and measure the request-to-send phase; returns on clock release.
  task automatic start_frame(input logic [7:0] d);
    int lo;
    int drise;
    dev_cap = '0;
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    check("busy_after_wr", 32'(busy), 32'd1);
    lo    = 0;
    drise = 0;
    while (ps2c_drive_low && lo < 100) begin
      lo++;
      if (ps2d_drive_low && drise == 0) drise = lo;
      @(negedge clk);
    end
    check("clk_inhibit_cycles", 32'(lo), 32'(INHIBIT));
    check("data_low_cycle", 32'(drise), 32'(INHIBIT));
    check("start_bit_held", 32'(ps2d_drive_low), 32'd1);
  endtask

  // Device side: 11 falling edges, data sampled on rising edges, optional disturbances.
  task automatic device_frame(input logic ack_low, input int glitch_edge,
                              input int wr_edge, input int reset_edge);
    int k;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        dev_d = ~ack_low;
        repeat (5) @(negedge clk);
      end
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_c = 1'b1;
      if (i < 10) dev_cap[i] = ps2d_in;
      if (i == 10) dev_d = 1'b1;
      if (i + 1 == glitch_edge) begin
        repeat (HALF / 2) @(negedge clk);
        dev_c = 1'b0;
        @(negedge clk);
        dev_c = 1'b1;
        repeat (HALF / 2 - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (i + 1 == wr_edge) begin
        din    = 8'h55;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        check("busy_mid_frame", 32'(busy), 32'd1);
      end
      if (i + 1 == reset_edge) begin
        #2 reset = 1'b1;
        #1;
        check("async_rst_clk", 32'(ps2c_drive_low), 32'd0);
        check("async_rst_dat", 32'(ps2d_drive_low), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
    end
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("busy_cleared", 32'(busy), 32'd0);
    repeat (30) @(negedge clk);
    check("lines_idle", 32'({ps2c_drive_low, ps2d_drive_low}), 32'd0);
  endtask

  // Monitor: pops one expectation for every result pulse.
  initial begin : monitor
    logic [11:0] act;
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (done_tick || ack_err) begin
        act = {ack_err, done_tick, dev_cap};
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_result: got %0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          check("frame_result", 32'(act), 32'(e));
        end
      end
    end
  end

  initial begin : bound
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation bound exceeded");
  end

  initial begin : stim
    int k;
    reset  = 1'b1;
    wr_ps2 = 1'b0;
    din    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_clk_low", 32'(ps2c_drive_low), 32'd0);
    check("rst_dat_low", 32'(ps2d_drive_low), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_tick), 32'd0);
    check("rst_err", 32'(ack_err), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED: bits 1,0,1,1,0,1,1,1 -> six ones, parity 1
    exp_q.push_back({2'b01, 1'b1, 1'b1, 8'hED});
    start_frame(8'hED);
    device_frame(1'b1, 0, 0, 0);

    exp_q.push_back({2'b01, 1'b1, 1'b1, 8'h00});
    start_frame(8'h00);
    device_frame(1'b1, 0, 0, 0);

    exp_q.push_back({2'b01, 1'b1, 1'b0, 8'h01});
    start_frame(8'h01);
    device_frame(1'b1, 0, 0, 0);

    // 0xA5 with a one-cycle clock glitch after edge 3
    exp_q.push_back({2'b01, 1'b1, 1'b1, 8'hA5});
    start_frame(8'hA5);
    device_frame(1'b1, 3, 0, 0);

    // 0x3C with a second request after edge 5
    exp_q.push_back({2'b01, 1'b1, 1'b1, 8'h3C});
    start_frame(8'h3C);
    device_frame(1'b1, 0, 5, 0);

    // 0xF4 (five ones, parity 0), device never pulls ack low
    exp_q.push_back({2'b10, 1'b1, 1'b0, 8'hF4});
    start_frame(8'hF4);
    device_frame(1'b0, 0, 0, 0);

    // Device never clocks: watchdog fires with nothing captured
    exp_q.push_back({2'b10, 10'b0});
    start_frame(8'h12);
    k = 0;
    while (!ack_err && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", 32'(k), 32'(TIMEOUT));
    check("timeout_lines", 32'({ps2c_drive_low, ps2d_drive_low}), 32'd0);
    @(negedge clk);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_err_pulse", 32'(ack_err), 32'd0);
    repeat (20) @(negedge clk);

    // Reset mid-frame after edge 4, then a normal 0xFF (eight ones, parity 1)
    start_frame(8'h81);
    device_frame(1'b1, 0, 0, 4);
    repeat (20) @(negedge clk);
    exp_q.push_back({2'b01, 1'b1, 1'b1, 8'hFF});
    start_frame(8'hFF);
    device_frame(1'b1, 0, 0, 0);

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
